// File: rtl/spi_pkg.sv
// Shared SPI master definitions: state encoding, frame width, default timing.
package spi_pkg;
  localparam int SPI_BITS    = 8;
  localparam int CLK_DIV_DEF = 32;
  localparam int CS_GAP_DEF  = 2;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SCK_LO,
    SCK_HI,
    HOLD,
    GAP
  } state_t;

  // Latched transfer request; data doubles as the tx shift register.
  typedef struct packed {
    logic                keep;
    logic [SPI_BITS-1:0] data;
  } spi_req_t;
endpackage

// File: rtl/spi_master_tx_if.sv
// Host handshake plus SPI pins of spi_master_tx.
// Optional SPI_RXCHECK_EN adds expect_data / rx_err.
interface spi_master_tx_if;
  import spi_pkg::*;

  logic                start;
  logic                keep_ssel;
  logic [SPI_BITS-1:0] byte_data_send;
  logic                ready;
  logic                busy;
  logic                done;
  logic [SPI_BITS-1:0] byte_data_received;
  logic                SCK;
  logic                SSEL;
  logic                MOSI;
  logic                MISO;
`ifdef SPI_RXCHECK_EN
  logic [SPI_BITS-1:0] expect_data;
  logic                rx_err;
`endif

  modport master (
    input  start, keep_ssel, byte_data_send, MISO,
`ifdef SPI_RXCHECK_EN
    input  expect_data,
    output rx_err,
`endif
    output ready, busy, done, byte_data_received, SCK, SSEL, MOSI
  );

  modport slave (
    output start, keep_ssel, byte_data_send, MISO,
`ifdef SPI_RXCHECK_EN
    output expect_data,
    input  rx_err,
`endif
    input  ready, busy, done, byte_data_received, SCK, SSEL, MOSI
  );
endinterface

// File: rtl/spi_clk_div.sv
// Half-period timer: free-runs while enabled, tick on the last cycle of each half-period.
module spi_clk_div #(
  parameter int CLK_DIV = 32
) (
  input  logic clk,
  input  logic rst_l,
  input  logic en,
  output logic tick,
  output logic first
);
  localparam logic [7:0] TC = 8'(CLK_DIV - 1);

  logic [7:0] cnt;

  // Held at zero while disabled so every active state starts a fresh half-period.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)                cnt <= 8'd0;
    else if (!en || cnt == TC) cnt <= 8'd0;
    else                       cnt <= cnt + 8'd1;
  end

  assign tick  = en && (cnt == TC);
  assign first = en && (cnt == 8'd0);
endmodule

// File: rtl/spi_master_tx.sv
// SPI mode-0 byte master with optional SSEL hold between bytes.
// Define SPI_RXCHECK_EN to add the received-byte comparator and sticky rx_err.
module spi_master_tx
  import spi_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF,
  parameter int CS_GAP  = CS_GAP_DEF
) (
  input  logic            clk,
  input  logic            rst_l,
  spi_master_tx_if.master bus
);
  localparam logic [3:0] GAP_TC  = 4'(CS_GAP - 1);
  localparam logic [2:0] LAST_BIT = 3'(SPI_BITS - 1);

  state_t              state, state_d;
  spi_req_t            req_q;
  logic [SPI_BITS-1:0] rx_sr, rx_q;
  logic [2:0]          bit_cnt;
  logic [3:0]          gap_cnt;
  logic                miso_q, sck_q, ssel_q, mosi_q, done_q;
  logic                tick, first, div_en, ready_w;
  logic                load, shift, finish;

  assign div_en  = (state == SETUP) || (state == SCK_LO) ||
                   (state == SCK_HI) || (state == GAP);
  // The done cycle already sits in HOLD/GAP; masking it keeps that cycle non-ready.
  assign ready_w = ((state == IDLE) || (state == HOLD)) && !done_q;

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk   (clk),
    .rst_l (rst_l),
    .en    (div_en),
    .tick  (tick),
    .first (first)
  );

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    load    = 1'b0;
    shift   = 1'b0;
    finish  = 1'b0;
    case (state)
      IDLE, HOLD: if (bus.start && ready_w) begin
        load    = 1'b1;
        state_d = SETUP;
      end
      SETUP, SCK_LO: if (tick) state_d = SCK_HI;
      SCK_HI: if (tick) begin
        if (bit_cnt == LAST_BIT) begin
          finish  = 1'b1;
          state_d = req_q.keep ? HOLD : GAP;
        end else begin
          shift   = 1'b1;
          state_d = SCK_LO;
        end
      end
      GAP: if (tick && gap_cnt == GAP_TC) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      req_q   <= '0;
      rx_sr   <= '0;
      rx_q    <= '0;
      bit_cnt <= 3'd0;
      gap_cnt <= 4'd0;
      miso_q  <= 1'b0;
      sck_q   <= 1'b0;
      ssel_q  <= 1'b1;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      miso_q <= bus.MISO;
      done_q <= finish;
      sck_q  <= (state_d == SCK_HI);
      if (load) begin
        req_q   <= '{keep: bus.keep_ssel, data: bus.byte_data_send};
        mosi_q  <= bus.byte_data_send[SPI_BITS-1];
        ssel_q  <= 1'b0;
        bit_cnt <= 3'd0;
      end else if (shift) begin
        req_q.data <= {req_q.data[SPI_BITS-2:0], 1'b0};
        mosi_q     <= req_q.data[SPI_BITS-2];
        bit_cnt    <= bit_cnt + 3'd1;
      end else if (finish) begin
        rx_q <= rx_sr;
        if (!req_q.keep) begin
          ssel_q <= 1'b1;
          mosi_q <= 1'b0;
        end
      end
      if (state == SCK_HI && first) rx_sr <= {rx_sr[SPI_BITS-2:0], miso_q};
      if (state != GAP) gap_cnt <= 4'd0;
      else if (tick)    gap_cnt <= gap_cnt + 4'd1;
    end
  end

`ifdef SPI_RXCHECK_EN
  logic [SPI_BITS-1:0] expect_q;
  logic                rx_err_q;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      expect_q <= '0;
      rx_err_q <= 1'b0;
    end else begin
      if (load) expect_q <= bus.expect_data;
      if (finish && rx_sr != expect_q) rx_err_q <= 1'b1;
    end
  end

  assign bus.rx_err = rx_err_q;
`endif

  assign bus.ready              = ready_w;
  assign bus.busy               = (state != IDLE);
  assign bus.done               = done_q;
  assign bus.byte_data_received = rx_q;
  assign bus.SCK                = sck_q;
  assign bus.SSEL               = ssel_q;
  assign bus.MOSI               = mosi_q;
endmodule

// File: tb/tb_spi_master_tx.sv
// Directed bench for spi_master_tx: vector table of single frames plus
// hand sequences for hold, ignored starts, mid-byte reset and the rx checker.
module tb_spi_master_tx;
  import spi_pkg::*;

  localparam int CLK_DIV = 4;
  localparam int CS_GAP  = 2;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  always #5 clk = ~clk;

  spi_master_tx_if bus();

  spi_master_tx #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  int         rises, dones, ssel_rises;
  logic [7:0] mosi_sh, slave_sr, slave_byte;
  logic       loopback;

  always @(posedge bus.SCK) begin
    rises++;
    mosi_sh = {mosi_sh[6:0], bus.MOSI};
  end
  always @(posedge bus.SSEL) ssel_rises++;
  always @(posedge clk) if (bus.done === 1'b1) dones++;
  always @(negedge bus.SSEL) slave_sr = slave_byte;
  always @(negedge bus.SCK) slave_sr = {slave_sr[6:0], 1'b0};

  assign bus.MISO = loopback ? bus.MOSI : slave_sr[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    rises = 0; dones = 0; ssel_rises = 0; mosi_sh = 8'h00;
  endtask

  task automatic start_byte(input logic [7:0] d, input logic keep);
    int n = 0;
    while (bus.ready !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    check("ready_before_start", {31'd0, bus.ready}, 32'd1);
    bus.start = 1'b1; bus.byte_data_send = d; bus.keep_ssel = keep;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_start", {31'd0, bus.busy}, 32'd1);
    check("ssel_low_after_start", {31'd0, bus.SSEL}, 32'd0);
  endtask

  task automatic wait_done(input logic [7:0] exp_rx, input string tag);
    int n = 0;
    while (bus.done !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    check({tag, "_done_seen"}, {31'd0, bus.done}, 32'd1);
    check({tag, "_ready_in_done"}, {31'd0, bus.ready}, 32'd0);
    check({tag, "_rx"}, {24'd0, bus.byte_data_received}, {24'd0, exp_rx});
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    int g = 0;
    while (bus.busy === 1'b1 && n < 300) begin
      if (bus.SSEL === 1'b1) g++;
      @(negedge clk); n++;
    end
    check({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
    check({tag, "_gap_len"}, g, CS_GAP * CLK_DIV);
    check({tag, "_ready_idle"}, {31'd0, bus.ready}, 32'd1);
  endtask

  typedef struct {
    logic [7:0] tx;
    logic       lp;
    logic [7:0] sl;
    logic [7:0] rx;
  } vec_t;

  vec_t vecs [4];

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{tx: 8'hA5, lp: 1'b1, sl: 8'h00, rx: 8'hA5};
    vecs[1] = '{tx: 8'hFF, lp: 1'b0, sl: 8'h3C, rx: 8'h3C};
    vecs[2] = '{tx: 8'h5A, lp: 1'b0, sl: 8'hC3, rx: 8'hC3};
    vecs[3] = '{tx: 8'h81, lp: 1'b1, sl: 8'h00, rx: 8'h81};

    bus.start = 1'b0; bus.keep_ssel = 1'b0; bus.byte_data_send = 8'h00;
`ifdef SPI_RXCHECK_EN
    bus.expect_data = 8'h00;
`endif
    loopback = 1'b1; slave_byte = 8'h00; slave_sr = 8'h00;
    clear_mon();

    repeat (3) @(negedge clk);
    check("rst_sck",   {31'd0, bus.SCK},   32'd0);
    check("rst_ssel",  {31'd0, bus.SSEL},  32'd1);
    check("rst_mosi",  {31'd0, bus.MOSI},  32'd0);
    check("rst_done",  {31'd0, bus.done},  32'd0);
    check("rst_busy",  {31'd0, bus.busy},  32'd0);
    check("rst_ready", {31'd0, bus.ready}, 32'd1);
    check("rst_rx",    {24'd0, bus.byte_data_received}, 32'd0);
    rst_l = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      loopback = vecs[i].lp; slave_byte = vecs[i].sl;
      clear_mon();
      start_byte(vecs[i].tx, 1'b0);
      wait_done(vecs[i].rx, $sformatf("vec%0d", i));
      wait_idle($sformatf("vec%0d", i));
      check($sformatf("vec%0d_rises", i), rises, 8);
      check($sformatf("vec%0d_dones", i), dones, 1);
      check($sformatf("vec%0d_mosi", i), {24'd0, mosi_sh}, {24'd0, vecs[i].tx});
      check($sformatf("vec%0d_ssel_rises", i), ssel_rises, 1);
    end

    // Back-to-back bytes with SSEL held low between them.
    loopback = 1'b1;
    clear_mon();
    start_byte(8'h61, 1'b1);
    wait_done(8'h61, "b2b0");
    @(negedge clk);
    check("b2b_hold_ssel", {31'd0, bus.SSEL}, 32'd0);
    start_byte(8'h62, 1'b0);
    wait_done(8'h62, "b2b1");
    wait_idle("b2b");
    check("b2b_rises", rises, 16);
    check("b2b_dones", dones, 2);
    check("b2b_ssel_rises", ssel_rises, 1);
    check("b2b_mosi", {24'd0, mosi_sh}, 32'h62);

    // Starts during SCK_LO and during the done cycle are dropped; HOLD waits.
    clear_mon();
    start_byte(8'hC3, 1'b1);
    begin
      int n = 0;
      while (!(rises >= 2 && bus.SCK === 1'b0) && n < 300) begin @(negedge clk); n++; end
    end
    check("ign_in_sck_lo", {31'd0, bus.ready}, 32'd0);
    bus.start = 1'b1; bus.byte_data_send = 8'h00; bus.keep_ssel = 1'b0;
    repeat (2) @(negedge clk);
    bus.start = 1'b0;
    wait_done(8'hC3, "ign");
    bus.start = 1'b1; bus.byte_data_send = 8'h11; bus.keep_ssel = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (40) @(negedge clk);
    check("ign_rises", rises, 8);
    check("ign_dones", dones, 1);
    check("ign_hold_busy", {31'd0, bus.busy}, 32'd1);
    check("ign_hold_ssel", {31'd0, bus.SSEL}, 32'd0);
    check("ign_hold_sck",  {31'd0, bus.SCK},  32'd0);
    check("ign_hold_ready", {31'd0, bus.ready}, 32'd1);
    check("ign_mosi", {24'd0, mosi_sh}, 32'hC3);
    start_byte(8'h5A, 1'b0);
    wait_done(8'h5A, "ign_end");
    wait_idle("ign_end");
    check("ign_total_rises", rises, 16);
    check("ign_total_dones", dones, 2);

    // Reset after the third SCK rise aborts the byte.
    clear_mon();
    start_byte(8'h96, 1'b0);
    begin
      int n = 0;
      while (rises < 3 && n < 300) begin @(negedge clk); n++; end
    end
    check("rst_mid_rises_seen", rises, 3);
    rst_l = 1'b0;
    #1;
    check("rst_mid_ssel",  {31'd0, bus.SSEL},  32'd1);
    check("rst_mid_sck",   {31'd0, bus.SCK},   32'd0);
    check("rst_mid_busy",  {31'd0, bus.busy},  32'd0);
    check("rst_mid_ready", {31'd0, bus.ready}, 32'd1);
    repeat (2) @(negedge clk);
    check("rst_mid_no_done", dones, 0);
    rst_l = 1'b1;
    clear_mon();
    start_byte(8'h69, 1'b0);
    wait_done(8'h69, "post_rst");
    wait_idle("post_rst");
    check("post_rst_rises", rises, 8);
    check("post_rst_mosi", {24'd0, mosi_sh}, 32'h69);

`ifdef SPI_RXCHECK_EN
    rst_l = 1'b0;
    @(negedge clk);
    rst_l = 1'b1;
    check("rxerr_reset", {31'd0, bus.rx_err}, 32'd0);
    loopback = 1'b1;
    bus.expect_data = 8'h61;
    start_byte(8'h62, 1'b0);
    wait_done(8'h62, "rxerr_bad");
    check("rxerr_set", {31'd0, bus.rx_err}, 32'd1);
    wait_idle("rxerr_bad");
    bus.expect_data = 8'h62;
    start_byte(8'h62, 1'b0);
    wait_done(8'h62, "rxerr_good");
    check("rxerr_sticky", {31'd0, bus.rx_err}, 32'd1);
    wait_idle("rxerr_good");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
